// File: rtl/mem_pkg.sv
// Shared memory-map constants, arbiter state encoding and requester indices.
package mem_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;
  localparam int unsigned REQ_N  = 2;
  localparam int unsigned CNT_W  = 8;

  // BRAM DMEM window: [ADDR_LO_DEF, ADDR_HI_DEF)
  localparam logic [ADDR_W-1:0] ADDR_LO_DEF = 32'h0020_0000;
  localparam logic [ADDR_W-1:0] ADDR_HI_DEF = 32'h0025_0000;

  localparam int unsigned REQ_LSU = 0;
  localparam int unsigned REQ_DMA = 1;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  // Unsigned half-open window test on the full byte address.
  function automatic logic in_range(input logic [ADDR_W-1:0] addr,
                                    input logic [ADDR_W-1:0] lo,
                                    input logic [ADDR_W-1:0] hi);
    return (addr >= lo) && (addr < hi);
  endfunction

endpackage

// File: rtl/bram_port_arbiter_if.sv
// Requester-side bus of the port B arbiter: two requesters sharing one response path.
interface bram_port_arbiter_if;
  import mem_pkg::*;

  logic [REQ_N-1:0]  req;
  logic [REQ_N-1:0]  lock;
  logic [BE_W-1:0]   we0;
  logic [BE_W-1:0]   we1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic [REQ_N-1:0]  gnt;
  logic [REQ_N-1:0]  rvalid;
  logic [REQ_N-1:0]  err;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, lock, we0, we1, addr0, addr1, wdata0, wdata1,
    input  gnt, rvalid, err, rdata
  );

  modport slave (
    input  req, lock, we0, we1, addr0, addr1, wdata0, wdata1,
    output gnt, rvalid, err, rdata
  );

endinterface

// File: rtl/bram_port_arbiter_rr_pick2.sv
// Two-way round-robin picker: a lone request wins, a tie goes to the one not served last.
module rr_pick2
  import mem_pkg::*;
(
  input  logic [REQ_N-1:0] req,
  input  logic             last,
  output logic [REQ_N-1:0] pick
);

  // Tie-break toward ~last; otherwise pass the single request through.
  always_comb begin
    pick = req;
    if (req == 2'b11) begin
      pick = last ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/bram_port_arbiter.sv
// Shares BRAM port B between the LSU and the debug DMA with round-robin
// arbitration, bounded lock bursts and a range check on every access.
module bram_port_arbiter
  import mem_pkg::*;
#(
  parameter logic [ADDR_W-1:0] ADDR_LO  = ADDR_LO_DEF,
  parameter logic [ADDR_W-1:0] ADDR_HI  = ADDR_HI_DEF,
  parameter int unsigned       LOCK_MAX = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  bram_port_arbiter_if.slave  bus,
  output logic [BE_W-1:0]     web,
  output logic [ADDR_W-1:0]   addrb,
  output logic [DATA_W-1:0]   dib,
  input  logic [DATA_W-1:0]   dob
);

  arb_state_e        state_q;
  arb_state_e        state_d;
  logic              last_q;
  logic              last_d;
  logic [CNT_W-1:0]  lock_cnt;
  logic [CNT_W-1:0]  cnt_d;
  logic [REQ_N-1:0]  pick;
  logic [REQ_N-1:0]  gnt_c;
  logic [REQ_N-1:0]  gnt;
  logic              sel;
  logic              hit;
  logic [BE_W-1:0]   we_sel;
  logic [REQ_N-1:0]  vld_q;
  logic              owner_q;
  logic              hit_q;

  rr_pick2 u_pick (
    .req  (bus.req),
    .last (last_q),
    .pick (pick)
  );

  // Arbitration state: FSM, most recent grantee, lock burst counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ARB;
      last_q   <= 1'b1;
      lock_cnt <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      lock_cnt <= cnt_d;
    end
  end

  // Grant selection and lock entry/exit; in LOCKED the owner is last_q.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = lock_cnt;
    gnt_c   = '0;
    unique case (state_q)
      ARB: begin
        gnt_c = pick;
        if (|pick) begin
          last_d = pick[1];
          if (bus.lock[pick[1]] && (LOCK_MAX > 1)) begin
            state_d = LOCKED;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      LOCKED: begin
        if (bus.req[last_q]) begin
          gnt_c[last_q] = 1'b1;
          cnt_d         = lock_cnt + CNT_W'(1);
        end
        if (!bus.req[last_q] || !bus.lock[last_q] ||
            (cnt_d == CNT_W'(LOCK_MAX))) begin
          state_d = ARB;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ARB;
        cnt_d   = '0;
      end
    endcase
  end

  // Grant is forced low while reset is asserted so no write can slip through.
  assign gnt     = rst_n ? gnt_c : '0;
  assign bus.gnt = gnt;

  // Port B drive: steer the granted requester (requester 0 when idle), gate writes by hit.
  assign sel    = gnt[REQ_DMA];
  assign addrb  = sel ? bus.addr1  : bus.addr0;
  assign dib    = sel ? bus.wdata1 : bus.wdata0;
  assign we_sel = sel ? bus.we1    : bus.we0;
  assign hit    = in_range(addrb, ADDR_LO, ADDR_HI);
  assign web    = ((|gnt) && hit) ? we_sel : '0;

  // Response tracking: one entry per cycle, aligned with the BRAM's read latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q   <= '0;
      owner_q <= 1'b0;
      hit_q   <= 1'b0;
    end else begin
      vld_q   <= gnt;
      owner_q <= sel;
      hit_q   <= hit;
    end
  end

  assign bus.rvalid       = vld_q;
  assign bus.err[REQ_LSU] = vld_q[REQ_LSU] & ~owner_q & ~hit_q;
  assign bus.err[REQ_DMA] = vld_q[REQ_DMA] &  owner_q & ~hit_q;
  assign bus.rdata        = ((|vld_q) && hit_q) ? dob : '0;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Bench for bram_port_arbiter: directed scenarios plus random traffic against
// a transaction-level model of the arbitration rules and the memory contents.
module tb_bram_port_arbiter;

  localparam int unsigned LMAX = 4;
  localparam logic [31:0] LO   = 32'h0020_0000;
  localparam logic [31:0] HI   = 32'h0025_0000;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  web;
  logic [31:0] addrb;
  logic [31:0] dib;
  logic [31:0] dob;

  int n_chk  = 0;
  int n_fail = 0;

  bram_port_arbiter_if bus ();

  bram_port_arbiter #(
    .ADDR_LO  (LO),
    .ADDR_HI  (HI),
    .LOCK_MAX (LMAX)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .web   (web),
    .addrb (addrb),
    .dib   (dib),
    .dob   (dob)
  );

  always #5 clk = ~clk;

  // Read-first BRAM, one cycle of read latency.
  logic [31:0] bram [bit [29:0]];
  logic [31:0] bw;
  always @(posedge clk) begin
    bw = bram.exists(addrb[31:2]) ? bram[addrb[31:2]] : 32'h0;
    dob <= bw;
    if (|web) begin
      for (int b = 0; b < 4; b++) if (web[b]) bw[8*b +: 8] = dib[8*b +: 8];
      bram[addrb[31:2]] = bw;
    end
  end

  // Reference model state: memory image, last winner, current burst owner and length.
  logic [31:0] mmem [bit [29:0]];
  int          m_last = 1;
  int          m_own  = -1;
  int          m_run  = 0;
  logic [1:0]  p_vld  = 2'b00;
  logic [1:0]  p_err  = 2'b00;
  logic [31:0] p_rdata = 32'h0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mread(input logic [31:0] a);
    return mmem.exists(a[31:2]) ? mmem[a[31:2]] : 32'h0;
  endfunction

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    mmem[a[31:2]] = d;
    bram[a[31:2]] = d;
  endtask

  task automatic model_reset();
    m_last  = 1;
    m_own   = -1;
    m_run   = 0;
    p_vld   = 2'b00;
    p_err   = 2'b00;
    p_rdata = 32'h0;
  endtask

  // One clock: inputs already applied at the falling edge; check, advance model, tick.
  task automatic step();
    logic [1:0]  eg;
    int          w;
    logic [31:0] ea, ed, old;
    logic [3:0]  ew, ewe;
    logic        hit;
    #1;
    check_eq("rvalid", 32'(bus.rvalid), 32'(p_vld));
    check_eq("err",    32'(bus.err),    32'(p_err));
    check_eq("rdata",  bus.rdata,       p_rdata);
    eg = 2'b00;
    if (m_own >= 0) begin
      if (bus.req[m_own]) begin
        eg[m_own] = 1'b1;
        m_run++;
      end
      if (!bus.req[m_own] || !bus.lock[m_own] || m_run >= int'(LMAX)) m_own = -1;
    end else begin
      if (bus.req == 2'b11)  w = 1 - m_last;
      else if (bus.req[0])   w = 0;
      else if (bus.req[1])   w = 1;
      else                   w = -1;
      if (w >= 0) begin
        eg[w]  = 1'b1;
        m_last = w;
        if (bus.lock[w] && (LMAX > 1)) begin
          m_own = w;
          m_run = 1;
        end
      end
    end
    ea  = eg[1] ? bus.addr1  : bus.addr0;
    ed  = eg[1] ? bus.wdata1 : bus.wdata0;
    ew  = eg[1] ? bus.we1    : bus.we0;
    hit = (ea >= LO) && (ea < HI);
    ewe = ((eg != 2'b00) && hit) ? ew : 4'h0;
    check_eq("gnt",   32'(bus.gnt), 32'(eg));
    check_eq("web",   32'(web),     32'(ewe));
    check_eq("addrb", addrb,        ea);
    check_eq("dib",   dib,          ed);
    old     = mread(ea);
    p_vld   = eg;
    p_err   = hit ? 2'b00 : eg;
    p_rdata = ((eg != 2'b00) && hit) ? old : 32'h0;
    if (ewe != 4'h0) begin
      for (int b = 0; b < 4; b++) if (ewe[b]) old[8*b +: 8] = ed[8*b +: 8];
      mmem[ea[31:2]] = old;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic [1:0] rq, input logic [1:0] lk,
                       input logic [3:0] w0, input logic [31:0] a0, input logic [31:0] d0,
                       input logic [3:0] w1, input logic [31:0] a1, input logic [31:0] d1);
    bus.req = rq; bus.lock = lk;
    bus.we0 = w0; bus.addr0 = a0; bus.wdata0 = d0;
    bus.we1 = w1; bus.addr1 = a1; bus.wdata1 = d1;
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 5))
      0, 1, 2: return LO + 32'($urandom_range(0, 31)) * 32'd4 + 32'($urandom_range(0, 3));
      3:       return HI - 32'($urandom_range(1, 4));
      4:       return ($urandom_range(0, 1) != 0) ? HI : LO - 32'd1;
      default: return 32'($urandom());
    endcase
  endfunction

  initial begin
    drive(2'b00, 2'b00, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0);

    // Reset values
    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_gnt",    32'(bus.gnt),    32'h0);
    check_eq("rst_rvalid", 32'(bus.rvalid), 32'h0);
    check_eq("rst_err",    32'(bus.err),    32'h0);
    check_eq("rst_rdata",  bus.rdata,       32'h0);
    check_eq("rst_web",    32'(web),        32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: single LSU read
    preload(32'h0020_0010, 32'hDEAD_BEEF);
    drive(2'b01, 2'b00, 4'h0, 32'h0020_0010, 32'h0, 4'h0, 32'h0, 32'h0);
    step();
    drive(2'b00, 2'b00, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0);
    #1;
    check_eq("t1_rdata",  bus.rdata,       32'hDEAD_BEEF);
    check_eq("t1_rvalid", 32'(bus.rvalid), 32'h1);
    step();

    // 2: continuous contention without lock alternates
    drive(2'b11, 2'b00, 4'h0, LO + 32'h20, 32'h0, 4'h0, LO + 32'h24, 32'h0);
    repeat (4) step();

    // 3: DMA lock burst capped at LMAX while LSU waits
    drive(2'b11, 2'b10, 4'h0, LO + 32'h20, 32'h0, 4'h0, LO + 32'h10, 32'h0);
    repeat (8) step();
    drive(2'b00, 2'b00, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0);
    step();

    // 4: out-of-range write is dropped and flagged
    drive(2'b10, 2'b00, 4'h0, 32'h0, 32'h0, 4'hF, 32'h0010_0000, 32'hCAFE_F00D);
    step();
    drive(2'b10, 2'b00, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0010_0000, 32'h0);
    #1;
    check_eq("t4_err",    32'(bus.err), 32'h2);
    check_eq("t4_rdata",  bus.rdata,    32'h0);
    step();
    check_eq("t4_nowrite", 32'(bram.exists(30'h0004_0000)), 32'h0);

    // 5: partial write returns the old word, next read sees the merge
    preload(32'h0020_0000, 32'hAAAA_AAAA);
    drive(2'b01, 2'b00, 4'h3, 32'h0020_0000, 32'h1234_5678, 4'h0, 32'h0, 32'h0);
    step();
    drive(2'b01, 2'b00, 4'h0, 32'h0020_0000, 32'h0, 4'h0, 32'h0, 32'h0);
    #1;
    check_eq("t5_old", bus.rdata, 32'hAAAA_AAAA);
    step();
    drive(2'b00, 2'b00, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0);
    #1;
    check_eq("t5_new", bus.rdata, 32'hAAAA_5678);
    step();

    // 6: reset in the middle of a locked burst
    drive(2'b10, 2'b10, 4'h0, LO, 32'h0, 4'hF, LO + 32'h40, 32'h5555_0000);
    repeat (2) step();
    bus.req = 2'b11;
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("t6_gnt",    32'(bus.gnt),    32'h0);
    check_eq("t6_rvalid", 32'(bus.rvalid), 32'h0);
    check_eq("t6_web",    32'(web),        32'h0);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    drive(2'b11, 2'b00, 4'h0, LO + 32'h4, 32'h0, 4'h0, LO + 32'h8, 32'h0);
    #1;
    check_eq("t6_first", 32'(bus.gnt), 32'h1);
    step();
    step();

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      drive(2'($urandom_range(0, 3)),
            {1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0)},
            4'($urandom()), rand_addr(), 32'($urandom()),
            4'($urandom()), rand_addr(), 32'($urandom()));
      if ($urandom_range(0, 3) == 0) bus.we0 = 4'h0;
      if ($urandom_range(0, 3) == 0) bus.we1 = 4'h0;
      step();
    end
    drive(2'b00, 2'b00, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/bram_port_arbiter.md
# bram_port_arbiter

Shares BRAM port B between two requesters: the core load/store unit (requester 0) and the debug/loader DMA (requester 1). It arbitrates round-robin, with an optional bounded lock for back-to-back bursts, and range-checks every address. It drives the BRAM's `web`/`addrb`/`dib` and steers `dob` back to the owner one cycle later. Port A (instruction fetch) is not touched.

## Interface
Parameters:
- `ADDR_LO`, 32'h00200000: lowest legal byte address (inclusive).
- `ADDR_HI`, 32'h00250000: highest legal byte address (exclusive).
- `LOCK_MAX`, 8: maximum consecutive grants one requester may hold via `lock`. Legal range is 1..255.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `req[1:0]`, in, 2: access request, one bit per requester.
- `lock[1:0]`, in, 2: owner asks to keep the grant next cycle.
- `we0`/`we1`, in, 4 each: byte write enables.
- `addr0`/`addr1`, in, 32 each: byte address.
- `wdata0`/`wdata1`, in, 32 each: write data.
- `gnt[1:0]`, out, 2: combinational grant, one-hot or zero.
- `rvalid[1:0]`, out, 2: response valid, registered.
- `err[1:0]`, out, 2: out-of-range flag, valid with `rvalid`.
- `rdata`, out, 32: response data, qualified by `rvalid`.
- `web`, out, 4: to BRAM.
- `addrb`, out, 32: to BRAM.
- `dib`, out, 32: to BRAM.
- `dob`, in, 32: from BRAM (read-first, 1-cycle latency).

## Operation
- Each cycle at most one requester is granted. A request completes in the cycle where `req[i] && gnt[i]`, and no further handshake is required.
- State registers:
  - `last` (1 bit): most recent grantee.
  - `owner_q` (1 bit), `hit_q` (1 bit), `vld_q` (2 bits): response tracking.
  - `lock_cnt` (8 bits).
  - FSM: `ARB` (free arbitration) and `LOCKED` (owner retained).
- `ARB` state:
  - A single request is granted.
  - If both request, grant `~last`.
  - On a grant with `lock[i]=1` and `LOCK_MAX>1`, go to `LOCKED` with `lock_cnt=1`.
- `LOCKED` state:
  - The owner is granted if it requests. The other requester is blocked.
  - On each owner grant, `lock_cnt++`.
  - Return to `ARB` when any of these holds: the owner deasserts `req` or `lock`, or `lock_cnt` reaches `LOCK_MAX`.
  - A cycle in which the owner drops `req` grants nobody; arbitration resumes next cycle.
- Forced release: after `LOCK_MAX` grants, `last` is set to the owner, so a waiting peer wins the next contention.
- Range check:
  - An access is a hit when `ADDR_LO <= addr < ADDR_HI`, compared unsigned on the full 32 bits.
  - A miss forces `web=0` (no write). The response carries `err=1` and `rdata=0`.
- Datapath muxing:
  - `addrb`/`dib` come from the granted requester, or from requester 0 when nobody is granted.
  - `web` equals `we` masked by grant and hit.
- Idle port: with no grant, `web=0`.
- Address alignment: `addr[1:0]` passes through unchanged. The BRAM ignores it.

## Timing
- Grant and BRAM drive happen in the same cycle t.
- Response at t+1:
  - `rvalid[owner]=1` for exactly one cycle.
  - `rdata=dob` on a hit, `0` on a miss.
  - Reads are read-first: a write at t returns the pre-write word.
- Back-to-back grants (either requester) give one response per cycle with full throughput.
- Reset values: `gnt=0`, `rvalid=0`, `err=0`, `rdata=0`, `web=0`, `last=1` (so requester 0 wins the first contention), FSM=`ARB`, `lock_cnt=0`.
- Reset mid-operation:
  - In-flight responses are dropped.
  - `rvalid` clears asynchronously.
  - The BRAM write in the reset cycle is suppressed because `web` is combinational from grant, and grant is 0 while `rst_n` is low.
- Simultaneous events:
  - Owner lock release and peer request in the same cycle: the peer is granted the next cycle, not the same cycle.
  - A requester asserting `lock` without a grant has no effect.

## Structure
- Shared package `mem_pkg`:
  - `ADDR_LO`/`ADDR_HI` defaults, matching the BRAM DMEM map.
  - FSM state encoding (`ARB`=0, `LOCKED`=1).
  - Requester index constants `REQ_LSU`=0, `REQ_DMA`=1.
- One sub-module, `rr_pick2`:
  - Combinational 2-way round-robin picker.
  - Inputs `req`, `last`; output one-hot `pick`.
- FSM, counters and response pipeline stay in the top.

## Test plan
1. Reset, then `req=01`, `addr0=0x00200010`, `we0=0`, BRAM word `0xDEADBEEF` → `gnt=01` at t; `rvalid=01`, `rdata=0xDEADBEEF`, `err=0` at t+1.
2. Both request continuously, no lock → grants alternate `01,10,01,10`, and each `rvalid` follows its grant by 1 cycle.
3. Requester 1 holds `lock=1` and `req=1` with `LOCK_MAX=4` while requester 0 requests → requester 1 gets 4 consecutive grants, then requester 0 is granted.
4. Write `we1=1111`, `addr1=0x00100000` (below `ADDR_LO`) → `web=0000`; next cycle `rvalid=10`, `err=10`, `rdata=0`; a subsequent read of that word shows it unchanged.
5. Write `0x12345678` with `we0=0011` to `0x00200000` (prior word `0xAAAAAAAA`) → response `rdata=0xAAAAAAAA`; a read the next cycle returns `0xAAAA5678`.
6. Deassert `rst_n` during a locked burst → `gnt`, `rvalid` and `web` are 0 immediately. After release, FSM is `ARB`, and contention grants requester 0 first.
